mux8to1_w8: RTL and testbench

- 8-input, 8-bit-wide multiplexer with a registered output.
- sel chooses one of eight data words x0..x7 and drives it onto o.
- Used as a generic datapath selector, e.g. a register-file read port or a bus source select.
- The output register gives timing isolation. A parameter allows a purely combinational build.

---
 rtl/mux_pkg.sv | 11 +
 rtl/mux4to1_w.sv | 25 ++
 rtl/mux8to1_w8.sv | 59 +++++
 tb/tb_mux8to1_w8.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the 8:1 selector family.
package mux_pkg;

    // Number of data inputs and the select width that indexes them.
    localparam int N_IN      = 8;
    localparam int SEL_W     = $clog2(N_IN);

    // Default data width for every input word and the output.
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/mux4to1_w.sv
// Width-parameterised combinational 4:1 selector, one half of the 8:1 tree.
module mux4to1_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] o
);

    // Pick one of four words; every code is legal so the case is full.
    always_comb begin
        o = x0;
        case (sel)
            2'd0: o = x0;
            2'd1: o = x1;
            2'd2: o = x2;
            2'd3: o = x3;
            default: o = x0;
        endcase
    end

endmodule

// File: rtl/mux8to1_w8.sv
// 8:1 WIDTH-bit selector built from two 4:1 halves and a final 2:1 stage,
// with an optional output register for timing isolation.
module mux8to1_w8
    import mux_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    input  logic [WIDTH-1:0] x4,
    input  logic [WIDTH-1:0] x5,
    input  logic [WIDTH-1:0] x6,
    input  logic [WIDTH-1:0] x7,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] o
);

    // Gather the inputs so each half can slice its four words by index.
    logic [N_IN-1:0][WIDTH-1:0] xv;
    assign xv = {x7, x6, x5, x4, x3, x2, x1, x0};

    // half[0] covers x0..x3, half[1] covers x4..x7; both share sel[1:0].
    logic [1:0][WIDTH-1:0] half;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_half
        mux4to1_w #(.WIDTH(WIDTH)) u_m4 (
            .x0  (xv[4*g+0]),
            .x1  (xv[4*g+1]),
            .x2  (xv[4*g+2]),
            .x3  (xv[4*g+3]),
            .sel (sel[1:0]),
            .o   (half[g])
        );
    end

    // Top select bit chooses between the two halves.
    logic [WIDTH-1:0] mux_o;
    assign mux_o = sel[SEL_W-1] ? half[1] : half[0];

    if (OUT_REG) begin : g_reg
        // Registered output; synchronous reset wins over selection.
        always_ff @(posedge clk) begin
            if (!rst_n) o <= '0;
            else        o <= mux_o;
        end
    end else begin : g_comb
        // Zero-latency build: clock and reset are intentionally unused.
        assign o = mux_o;
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
    end

endmodule

// File: tb/tb_mux8to1_w8.sv
// Scoreboard bench: registered DUT checked every cycle against a queue of
// expected words; a combinational build checked directly.
module tb_mux8to1_w8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0][7:0] xv;
    logic [2:0]      sel;
    logic [2:0]      sel_c;
    logic [7:0]      o;
    logic [7:0]      o_c;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mux8to1_w8 #(.WIDTH(8), .OUT_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .x0(xv[0]), .x1(xv[1]), .x2(xv[2]), .x3(xv[3]),
        .x4(xv[4]), .x5(xv[5]), .x6(xv[6]), .x7(xv[7]),
        .sel(sel), .o(o)
    );

    mux8to1_w8 #(.WIDTH(8), .OUT_REG(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .x0(xv[0]), .x1(xv[1]), .x2(xv[2]), .x3(xv[3]),
        .x4(xv[4]), .x5(xv[5]), .x6(xv[6]), .x7(xv[7]),
        .sel(sel_c), .o(o_c)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: what the register should load at this edge.
    always @(posedge clk) begin
        exp_q.push_back(!rst_n ? 8'h00 : xv[sel]);
    end

    // Compare on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) chk("sb", o, exp_q.pop_front());
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        sel   = 3'd5;
        sel_c = 3'd0;
        for (int i = 0; i < 8; i++) xv[i] = 8'(i * 8'h11);

        // Reset held for two edges, then release with sel=5.
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Sweep sel, 10 cycles per code.
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            cyc(10);
        end

        // Data change under a fixed select, then an unrelated input change.
        sel = 3'd3;
        cyc(2);
        xv[3] = 8'hA5;
        cyc(2);
        xv[2] = 8'hFF;
        cyc(2);

        // Reset mid-operation for one edge.
        xv[3] = 8'h33;
        xv[2] = 8'h22;
        sel   = 3'd7;
        cyc(3);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(3);

        // Simultaneous sel and data change.
        sel   = 3'd1;
        xv[1] = 8'h5A;
        cyc(2);
        xv[1] = 8'h11;

        // One-hot data, sweep sel.
        for (int i = 0; i < 8; i++) xv[i] = 8'(1 << i);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            cyc(2);
        end

        // Combinational build: no clock edge needed.
        for (int i = 0; i < 8; i++) xv[i] = 8'(i * 8'h11);
        sel_c = 3'd6;
        #1;
        chk("comb6", o_c, 8'h66);
        for (int s = 0; s < 8; s++) begin
            sel_c = 3'(s);
            #1;
            chk("comb", o_c, 8'(s * 8'h11));
        end
        xv[6] = 8'hC3;
        sel_c = 3'd6;
        #1;
        chk("comb_data", o_c, 8'hC3);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
